// File: rtl/mem_access_sequencer_if.sv
// Bundle between the memory access sequencer, the core datapath and the unified memory.
// Latency: none, wires only.
// Backpressure: mem_ready from memory stalls the sequencer; the core sees it through busy/PCWrite.
interface mem_access_sequencer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // datapath / decode side
  logic [AW-1:0] pc;
  logic [AW-1:0] alu_result;
  logic [DW-1:0] write_data;
  logic          MemWrite;
  logic          ResultSrc;
  logic [DW-1:0] instr;
  logic [DW-1:0] read_data;
  logic          PCWrite;
  logic          busy;
  logic          err;
  // memory side
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  modport master (
    input  pc, alu_result, write_data, MemWrite, ResultSrc, mem_ready, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, instr, read_data, PCWrite, busy, err
  );

  modport slave (
    output pc, alu_result, write_data, MemWrite, ResultSrc, mem_ready, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, instr, read_data, PCWrite, busy, err
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Shares one single-port memory between instruction fetch and load/store; PERF_CNT_EN adds perf counters.
// Latency: ALU instr 2 cycles, load/store 4 cycles with zero-wait memory, +1 per wait cycle.
// Backpressure: request held stable until mem_ready; MAX_WAIT-cycle stall ends in sticky ERROR.
module mem_access_sequencer #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_access_sequencer_if.master bus
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]            instr_count,
  output logic [31:0]            wait_count
`endif
);

  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DATA,
    S_WB,
    S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          req_c;
  logic          we_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdata_c;
  logic          pcwrite_c;

  // State, wait counter and latched instruction / load data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      instr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state and memory request; outputs decode from state so reset drops mem_req at once
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    instr_d   = instr_q;
    rdata_d   = rdata_q;
    req_c     = 1'b0;
    we_c      = 1'b0;
    addr_c    = '0;
    wdata_c   = '0;
    pcwrite_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        wait_d  = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = bus.pc;
        if (bus.mem_ready) begin
          instr_d = bus.mem_rdata;
          state_d = S_EXEC;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_EXEC: begin
        // Decode has had a cycle to settle on the new instr
        wait_d = '0;
        if (bus.MemWrite || bus.ResultSrc) begin
          state_d = S_DATA;
        end else begin
          pcwrite_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_DATA: begin
        req_c   = 1'b1;
        addr_c  = bus.alu_result;
        we_c    = bus.MemWrite;
        wdata_c = bus.write_data;
        if (bus.mem_ready) begin
          // MemWrite wins when both are set, so read_data is left alone
          if (bus.ResultSrc && !bus.MemWrite) begin
            rdata_d = bus.mem_rdata;
          end
          state_d = S_WB;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_WB: begin
        pcwrite_c = 1'b1;
        wait_d    = '0;
        state_d   = S_FETCH;
      end
      S_ERROR: begin
        wait_d  = '0;
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.mem_req   = req_c;
  assign bus.mem_we    = we_c;
  assign bus.mem_addr  = addr_c;
  assign bus.mem_wdata = wdata_c;
  assign bus.PCWrite   = pcwrite_c;
  assign bus.instr     = instr_q;
  assign bus.read_data = rdata_q;
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign bus.err       = (state_q == S_ERROR);

`ifdef PERF_CNT_EN
  logic [31:0] icnt_q, icnt_d;
  logic [31:0] wcnt_q, wcnt_d;

  // Retired-instruction and memory-stall counters, free-running with wrap
  always_comb begin
    icnt_d = icnt_q;
    wcnt_d = wcnt_q;
    if (pcwrite_c) begin
      icnt_d = icnt_q + 32'd1;
    end
    if (req_c && !bus.mem_ready) begin
      wcnt_d = wcnt_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icnt_q <= '0;
      wcnt_q <= '0;
    end else begin
      icnt_q <= icnt_d;
      wcnt_q <= wcnt_d;
    end
  end

  assign instr_count = icnt_q;
  assign wait_count  = wcnt_q;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer (MAX_WAIT=8); perf counter checks compile with PERF_CNT_EN.
// Latency: inputs driven 1 time unit after each rising edge, outputs checked 1 unit later.
// Backpressure: mem_ready is scripted per cycle to create waits and a fetch timeout.
module tb_mem_access_sequencer;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mem_access_sequencer_if #(.AW(32), .DW(32)) bus ();

`ifdef PERF_CNT_EN
  logic [31:0] instr_count;
  logic [31:0] wait_count;
`endif

  mem_access_sequencer #(
    .AW(32),
    .DW(32),
    .MAX_WAIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PERF_CNT_EN
    ,
    .instr_count(instr_count),
    .wait_count(wait_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst            = 1'b0;
    bus.pc         = 32'h0;
    bus.alu_result = 32'h0;
    bus.write_data = 32'h0;
    bus.MemWrite   = 1'b0;
    bus.ResultSrc  = 1'b0;
    bus.mem_ready  = 1'b1;
    bus.mem_rdata  = 32'h0000_0013;

    // Reset state
    tick();
    #1;
    chk("rst_req", bus.mem_req, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_rdata", bus.read_data, 0);
    chk("rst_pcw", bus.PCWrite, 0);

    // ALU instructions, zero-wait memory
    tick();
    rst = 1'b1;
    #1;
    chk("c0_req", bus.mem_req, 0);
    tick();
    #1;
    chk("c1_req", bus.mem_req, 1);
    chk("c1_addr", bus.mem_addr, 32'h0);
    chk("c1_we", bus.mem_we, 0);
    chk("c1_busy", bus.busy, 1);
    chk("c1_pcw", bus.PCWrite, 0);
    tick();
    #1;
    chk("c2_pcw", bus.PCWrite, 1);
    chk("c2_req", bus.mem_req, 0);
    chk("c2_instr", bus.instr, 32'h0000_0013);
    tick();
    bus.pc = 32'h4;
    #1;
    chk("c3_pcw", bus.PCWrite, 0);
    chk("c3_addr", bus.mem_addr, 32'h4);
    tick();
    #1;
    chk("c4_pcw", bus.PCWrite, 1);

    // Load, zero-wait
    tick();
    bus.pc        = 32'h8;
    bus.mem_rdata = 32'h0000_0003;
    #1;
    chk("ld_faddr", bus.mem_addr, 32'h8);
    tick();
    bus.ResultSrc  = 1'b1;
    bus.alu_result = 32'h100;
    #1;
    chk("ld_exec_pcw", bus.PCWrite, 0);
    chk("ld_exec_req", bus.mem_req, 0);
    chk("ld_instr", bus.instr, 32'h0000_0003);
    tick();
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_req", bus.mem_req, 1);
    chk("ld_addr", bus.mem_addr, 32'h100);
    chk("ld_we", bus.mem_we, 0);
    chk("ld_wdata", bus.mem_wdata, 0);
    tick();
    #1;
    chk("ld_wb_pcw", bus.PCWrite, 1);
    chk("ld_rdata", bus.read_data, 32'hDEAD_BEEF);
    chk("ld_wb_req", bus.mem_req, 0);

    // Store with 3 wait cycles in DATA
    tick();
    bus.ResultSrc = 1'b0;
    bus.pc        = 32'hC;
    bus.mem_rdata = 32'h0000_0023;
    #1;
    chk("st_faddr", bus.mem_addr, 32'hC);
    tick();
    bus.MemWrite   = 1'b1;
    bus.alu_result = 32'h200;
    bus.write_data = 32'hA5A5_A5A5;
    bus.mem_ready  = 1'b0;
    #1;
    chk("st_exec_pcw", bus.PCWrite, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) bus.mem_ready = 1'b1;
      #1;
      chk("st_req", bus.mem_req, 1);
      chk("st_we", bus.mem_we, 1);
      chk("st_addr", bus.mem_addr, 32'h200);
      chk("st_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
      chk("st_wait_pcw", bus.PCWrite, 0);
    end
    tick();
    #1;
    chk("st_wb_pcw", bus.PCWrite, 1);
    chk("st_wb_we", bus.mem_we, 0);
    chk("st_wb_wdata", bus.mem_wdata, 0);
    chk("st_rdata_keep", bus.read_data, 32'hDEAD_BEEF);

    // Illegal MemWrite+ResultSrc behaves as a store
    tick();
    bus.MemWrite  = 1'b0;
    bus.pc        = 32'h10;
    bus.mem_rdata = 32'h0000_0033;
    #1;
    tick();
    bus.MemWrite   = 1'b1;
    bus.ResultSrc  = 1'b1;
    bus.alu_result = 32'h180;
    #1;
    tick();
    bus.mem_rdata = 32'h1111_1111;
    #1;
    chk("il_we", bus.mem_we, 1);
    chk("il_addr", bus.mem_addr, 32'h180);
    tick();
    #1;
    chk("il_pcw", bus.PCWrite, 1);
    chk("il_rdata", bus.read_data, 32'hDEAD_BEEF);

    // Reset asserted during a DATA wait
    tick();
    bus.MemWrite  = 1'b0;
    bus.ResultSrc = 1'b0;
    bus.pc        = 32'h20;
    bus.mem_rdata = 32'h0000_0023;
    #1;
    tick();
    bus.MemWrite   = 1'b1;
    bus.alu_result = 32'h300;
    bus.mem_ready  = 1'b0;
    #1;
    tick();
    #1;
    chk("rm_req_before", bus.mem_req, 1);
    rst = 1'b0;
    #1;
    chk("rm_req_async", bus.mem_req, 0);
    chk("rm_instr", bus.instr, 0);
    chk("rm_err", bus.err, 0);
    chk("rm_busy", bus.busy, 0);
    tick();
    bus.MemWrite = 1'b0;
    bus.pc       = 32'h40;
    rst          = 1'b1;
    #1;
    tick();
    #1;
    chk("rm_fetch_req", bus.mem_req, 1);
    chk("rm_fetch_addr", bus.mem_addr, 32'h40);
    chk("rm_fetch_we", bus.mem_we, 0);

    // Fetch timeout with MAX_WAIT=8: request cycles 1..8, ERROR in cycle 9
    for (int i = 2; i <= 8; i++) begin
      tick();
      #1;
      chk("to_req", bus.mem_req, 1);
      chk("to_err", bus.err, 0);
    end
    tick();
    bus.mem_ready = 1'b1;
    #1;
    chk("to_err_set", bus.err, 1);
    chk("to_req_drop", bus.mem_req, 0);
    chk("to_busy", bus.busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("to_sticky_err", bus.err, 1);
      chk("to_no_pcw", bus.PCWrite, 0);
      chk("to_no_req", bus.mem_req, 0);
    end
    rst = 1'b0;
    #1;
    chk("to_rst_err", bus.err, 0);

`ifdef PERF_CNT_EN
    // 10 ALU instructions, one wait cycle in each fetch
    tick();
    #1;
    chk("pc_rst_icnt", instr_count, 0);
    chk("pc_rst_wcnt", wait_count, 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.mem_ready = 1'b0;
      tick();
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
    end
    tick();
    #1;
    chk("pc_icnt", instr_count, 10);
    chk("pc_wcnt", wait_count, 10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
